dbus_lsu_bridge: RTL

DBUS_LSU_BRIDGE -- requirements
Module: dbus_lsu_bridge

---
 rtl/dbus_lsu_bridge.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/dbus_lsu_bridge.sv
// Load/store unit to data-bus bridge: aligns CPU accesses onto bus lanes,
// waits for the bus acknowledge (with optional timeout) and formats load data.
module dbus_lsu_bridge #(
    parameter int unsigned P_DATA_W  = 32,
    parameter int unsigned P_ADDR_W  = 32,
    parameter int unsigned P_TIMEOUT = 255
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_Req,
    input  logic                  i_We,
    input  logic [2:0]            i_BusMode,
    input  logic [P_ADDR_W-1:0]   i_Addr,
    input  logic [P_DATA_W-1:0]   i_Wd,
    output logic                  o_Ready,
    output logic                  o_RspValid,
    output logic [P_DATA_W-1:0]   o_Rd,
    output logic [1:0]            o_Err,
    output logic [P_ADDR_W-$clog2(P_DATA_W/8)-1:0] o_DBus_Address,
    output logic [P_DATA_W/8-1:0] o_DBus_ByteEn,
    output logic                  o_DBus_Read,
    output logic                  o_DBus_Write,
    output logic [P_DATA_W-1:0]   o_DBus_WriteData,
    input  logic [P_DATA_W-1:0]   i_DBus_ReadData,
    input  logic                  i_DBus_Ack
);

    localparam int unsigned B       = P_DATA_W / 8;
    localparam int unsigned S       = $clog2(B);
    localparam int unsigned WA_W    = P_ADDR_W - S;
    localparam int unsigned CNT_W   = $clog2(P_TIMEOUT + 2);
    localparam int unsigned TO_LAST = (P_TIMEOUT == 0) ? 0 : P_TIMEOUT - 1;

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t             state, stateNext;
    logic [S-1:0]       offReg, offNext;
    logic [2:0]         modeReg, modeNext;
    logic [CNT_W-1:0]   cnt, cntNext;

    logic               readyNext, rspNext, readNext, writeNext;
    logic [1:0]         errNext;
    logic [P_DATA_W-1:0] rdNext, wdNext;
    logic [WA_W-1:0]    addrNext;
    logic [B-1:0]       beNext;

    logic [S-1:0]       off;
    logic               illegal;
    logic [7:0]         sizeMask;
    logic [P_DATA_W-1:0] shifted, dMask, loadData;
    logic               signBit;

    assign off = i_Addr[S-1:0];

    // Legality check and lane mask for the incoming request
    always_comb begin
        illegal  = 1'b0;
        sizeMask = 8'h01;
        case (i_BusMode[1:0])
            2'd0: begin illegal = 1'b0;             sizeMask = 8'h01; end
            2'd1: begin illegal = i_Addr[0];        sizeMask = 8'h03; end
            2'd2: begin illegal = |i_Addr[1:0];     sizeMask = 8'h0F; end
            default: begin
                illegal  = (P_DATA_W == 32) || (|i_Addr[2:0]);
                sizeMask = 8'hFF;
            end
        endcase
    end

    // Extract the addressed lane from bus read data and extend it
    always_comb begin
        shifted = i_DBus_ReadData >> {offReg, 3'b000};
        dMask   = '1;
        signBit = 1'b0;
        case (modeReg[1:0])
            2'd0: begin dMask = P_DATA_W'(8'hFF);         signBit = shifted[7];  end
            2'd1: begin dMask = P_DATA_W'(16'hFFFF);      signBit = shifted[15]; end
            2'd2: begin dMask = P_DATA_W'(32'hFFFF_FFFF); signBit = shifted[31]; end
            default: begin dMask = '1;                    signBit = 1'b0;        end
        endcase
        loadData = (shifted & dMask) | ((signBit && !modeReg[2]) ? ~dMask : '0);
    end

    // Next-state and next-output logic
    always_comb begin
        stateNext = state;
        readyNext = 1'b0;
        rspNext   = 1'b0;
        rdNext    = '0;
        errNext   = 2'b00;
        addrNext  = o_DBus_Address;
        beNext    = o_DBus_ByteEn;
        wdNext    = o_DBus_WriteData;
        readNext  = o_DBus_Read;
        writeNext = o_DBus_Write;
        offNext   = offReg;
        modeNext  = modeReg;
        cntNext   = cnt;
        case (state)
            IDLE: begin
                readyNext = 1'b1;
                if (i_Req) begin
                    readyNext = 1'b0;
                    addrNext  = i_Addr[P_ADDR_W-1:S];
                    beNext    = B'(sizeMask << off);
                    wdNext    = i_Wd << {off, 3'b000};
                    offNext   = off;
                    modeNext  = i_BusMode;
                    cntNext   = '0;
                    if (illegal) begin
                        stateNext = RESP;
                        rspNext   = 1'b1;
                        errNext   = 2'b01;
                    end else begin
                        stateNext = BUS;
                        readNext  = !i_We;
                        writeNext = i_We;
                    end
                end
            end
            BUS: begin
                if (i_DBus_Ack) begin
                    stateNext = RESP;
                    rspNext   = 1'b1;
                    rdNext    = o_DBus_Read ? loadData : '0;
                    readNext  = 1'b0;
                    writeNext = 1'b0;
                end else if ((P_TIMEOUT != 0) && (cnt == CNT_W'(TO_LAST))) begin
                    stateNext = RESP;
                    rspNext   = 1'b1;
                    errNext   = 2'b10;
                    readNext  = 1'b0;
                    writeNext = 1'b0;
                end else begin
                    cntNext = cnt + CNT_W'(1);
                end
            end
            RESP: begin
                stateNext = IDLE;
                readyNext = 1'b1;
            end
            default: begin
                stateNext = IDLE;
                readyNext = 1'b1;
            end
        endcase
    end

    // State and registered outputs; reset aborts any bus access at once
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state            <= IDLE;
            o_Ready          <= 1'b1;
            o_RspValid       <= 1'b0;
            o_Rd             <= '0;
            o_Err            <= 2'b00;
            o_DBus_Address   <= '0;
            o_DBus_ByteEn    <= '0;
            o_DBus_Read      <= 1'b0;
            o_DBus_Write     <= 1'b0;
            o_DBus_WriteData <= '0;
            offReg           <= '0;
            modeReg          <= '0;
            cnt              <= '0;
        end else begin
            state            <= stateNext;
            o_Ready          <= readyNext;
            o_RspValid       <= rspNext;
            o_Rd             <= rdNext;
            o_Err            <= errNext;
            o_DBus_Address   <= addrNext;
            o_DBus_ByteEn    <= beNext;
            o_DBus_Read      <= readNext;
            o_DBus_Write     <= writeNext;
            o_DBus_WriteData <= wdNext;
            offReg           <= offNext;
            modeReg          <= modeNext;
            cnt              <= cntNext;
        end
    end

endmodule
